// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / branch-on-load interlock driving PC, IF/ID and ID/EX controls.
// Optional HAZARD_STATS_EN adds saturating stall_cycles and load_use_events counters.
module hazard_stall_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rn,
    input  logic [4:0]  dec_rm,
    input  logic [4:0]  dec_rd,
    input  logic        dec_uses_rn,
    input  logic        dec_uses_rm,
    input  logic        dec_uses_rd,
    input  logic        dec_regwrite,
    input  logic        dec_memread,
    input  logic        dec_is_branch,
    input  logic        branch_taken,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [15:0] load_use_events,
`endif
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic [1:0]  stall_cause
);
    logic       ex_valid, ex_regwrite, ex_memread;
    logic       mem_valid, mem_regwrite, mem_memread;
    logic [4:0] ex_rd, mem_rd;
    logic       h1, h2, stall;

    function automatic logic hit(input logic used, input logic [4:0] s, input logic [4:0] r);
        return used && s == r && r != 5'd31;
    endfunction

    assign h1 = dec_valid && ex_valid && ex_memread && ex_regwrite &&
                (hit(dec_uses_rn, dec_rn, ex_rd) || hit(dec_uses_rm, dec_rm, ex_rd) ||
                 hit(dec_uses_rd, dec_rd, ex_rd));
    assign h2 = dec_valid && dec_is_branch && mem_valid && mem_memread && mem_regwrite &&
                hit(dec_uses_rd, dec_rd, mem_rd);
    assign stall = h1 || h2;

    assign pc_write_en    = !reset && !stall;
    assign if_id_write_en = !reset && !stall;
    assign id_ex_bubble   = reset || stall;
    assign if_id_flush    = reset || (!stall && branch_taken);
    assign stall_cause    = reset ? 2'b00 : h1 ? 2'b01 : h2 ? 2'b10 : 2'b00;

    // Shadow EX/MEM destination info; a stalled decode enters EX as a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
        end else begin
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            ex_valid     <= dec_valid && !stall;
            ex_rd        <= dec_rd;
            ex_regwrite  <= dec_regwrite;
            ex_memread   <= dec_memread;
        end
    end

`ifdef HAZARD_STATS_EN
    logic h1_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            h1_q            <= 1'b0;
            stall_cycles    <= '0;
            load_use_events <= '0;
        end else begin
            h1_q <= h1;
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (h1 && !h1_q && load_use_events != '1)
                load_use_events <= load_use_events + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vectors; driver queues expected controls, monitor checks each cycle.
module tb_hazard_stall_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_rn = '0, dec_rm = '0, dec_rd = '0;
    logic       dec_uses_rn = 1'b0, dec_uses_rm = 1'b0, dec_uses_rd = 1'b0;
    logic       dec_regwrite = 1'b0, dec_memread = 1'b0, dec_is_branch = 1'b0, branch_taken = 1'b0;
    logic       pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush;
    logic [1:0] stall_cause;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] load_use_events;
`endif

    localparam logic [5:0] IDLE = 6'b110000;
    localparam logic [5:0] LU   = 6'b001001;
    localparam logic [5:0] BL   = 6'b001010;
    localparam logic [5:0] FL   = 6'b110100;
    localparam logic [5:0] RST  = 6'b001100;

    typedef struct {
        logic [5:0] exp;
        string      nm;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;
    logic  done = 1'b0;

    hazard_stall_unit dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid),
        .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_rd(dec_rd),
        .dec_uses_rn(dec_uses_rn), .dec_uses_rm(dec_uses_rm), .dec_uses_rd(dec_uses_rd),
        .dec_regwrite(dec_regwrite), .dec_memread(dec_memread),
        .dec_is_branch(dec_is_branch), .branch_taken(branch_taken),
`ifdef HAZARD_STATS_EN
        .stall_cycles(stall_cycles), .load_use_events(load_use_events),
`endif
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .stall_cause(stall_cause)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic v, input logic [4:0] rn, input logic [4:0] rm,
                        input logic [4:0] rd, input logic [2:0] uses, input logic rw, input logic mr,
                        input logic br, input logic bt, input logic [5:0] exp, input string nm);
        item_t it;
        @(posedge clk);
        #1;
        reset = r; dec_valid = v; dec_rn = rn; dec_rm = rm; dec_rd = rd;
        {dec_uses_rn, dec_uses_rm, dec_uses_rd} = uses;
        dec_regwrite = rw; dec_memread = mr; dec_is_branch = br; branch_taken = bt;
        it.exp = exp;
        it.nm = nm;
        q.push_back(it);
    endtask

    task automatic ldur(input logic [4:0] rd, input logic [5:0] exp, input string nm);
        step(1'b0, 1'b1, 5'd1, 5'd0, rd, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, exp, nm);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [5:0] exp, input string nm);
        step(1'b0, 1'b1, rn, rm, rd, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, exp, nm);
    endtask

    task automatic cbz(input logic [4:0] rt, input logic bt, input logic [5:0] exp, input string nm);
        step(1'b0, 1'b1, 5'd0, 5'd0, rt, 3'b001, 1'b0, 1'b0, 1'b1, bt, exp, nm);
    endtask

    // Monitor: controls are combinational, so every driven cycle presents one response
    initial begin
        item_t      it;
        logic [5:0] got;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                it = q.pop_front();
                got = {pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, stall_cause};
                checks++;
                if (got !== it.exp) begin
                    errors++;
                    $display("FAIL %s got=%b expected=%b (pc,ifid,bubble,flush,cause)", it.nm, got, it.exp);
                end
            end
            if (done && q.size() == 0) break;
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cycles !== 32'd5) begin
            errors++;
            $display("FAIL stall_cycles got=%0d expected=5", stall_cycles);
        end
        checks++;
        if (load_use_events !== 16'd4) begin
            errors++;
            $display("FAIL load_use_events got=%0d expected=4", load_use_events);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 3'b110, 1'b1, 1'b1, 1'b0, 1'b1, RST, "reset0");
        step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 3'b110, 1'b1, 1'b1, 1'b0, 1'b1, RST, "reset1");
        alu(5'd10, 5'd1, 5'd2, IDLE, "post_reset");
        ldur(5'd3, IDLE, "ldur_x3");
        alu(5'd5, 5'd3, 5'd4, LU, "load_use");
        alu(5'd5, 5'd3, 5'd4, IDLE, "load_use_resume");
        ldur(5'd31, IDLE, "ldur_x31");
        alu(5'd5, 5'd31, 5'd4, IDLE, "x31_no_stall");
        ldur(5'd2, IDLE, "ldur_x2");
        cbz(5'd2, 1'b0, LU, "cbz_h1");
        cbz(5'd2, 1'b1, BL, "cbz_h2_taken_ignored");
        cbz(5'd2, 1'b1, FL, "cbz_flush");
        alu(5'd7, 5'd1, 5'd2, IDLE, "add_x7");
        cbz(5'd7, 1'b1, FL, "cbz_alu_flush");
        alu(5'd1, 5'd7, 5'd7, IDLE, "alu_after_cbz");
        ldur(5'd4, IDLE, "ldur_x4");
        step(1'b0, 1'b0, 5'd4, 5'd0, 5'd0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, "invalid_decode");
        cbz(5'd4, 1'b0, BL, "cbz_one_gap");
        cbz(5'd4, 1'b0, IDLE, "cbz_one_gap_resume");
        ldur(5'd6, IDLE, "ldur_x6");
        ldur(5'd8, IDLE, "ldur_x8");
        step(1'b0, 1'b1, 5'd8, 5'd0, 5'd6, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, LU, "h1_h2_both");
        step(1'b0, 1'b1, 5'd8, 5'd0, 5'd6, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, IDLE, "h1_h2_resume");
        ldur(5'd9, IDLE, "ldur_x9");
        cbz(5'd9, 1'b0, LU, "cbz_x9_stall");
        step(1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, RST, "reset_mid_stall");
        cbz(5'd9, 1'b0, IDLE, "cbz_x9_after_reset");
        for (int i = 0; i < 3; i++) begin
            ldur(5'd3, IDLE, "stats_ldur");
            alu(5'd5, 5'd3, 5'd4, LU, "stats_load_use");
            alu(5'd5, 5'd3, 5'd4, IDLE, "stats_resume");
        end
        ldur(5'd2, IDLE, "stats_ldur_x2");
        cbz(5'd2, 1'b0, LU, "stats_cbz_h1");
        cbz(5'd2, 1'b0, BL, "stats_cbz_h2");
        cbz(5'd2, 1'b0, IDLE, "stats_cbz_resume");
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, "final_idle");
        @(posedge clk);
        done = 1'b1;
    end
endmodule
